// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC in vectoring mode.
// Computes atan2(y, x) for non-negative fixed-point x and y.
// One micro-rotation is performed per enabled clock. The result is a
// signed angle in radians, with the same fraction width as the inputs.
module cordic_vectoring #(
  parameter int FRACS = 22,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS + 1,
  parameter int ITERS = FRACS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    start,
  output logic                    done,
  input  logic [WIDTH-2:0]        fixedPoint_x,
  input  logic [WIDTH-2:0]        fixedPoint_y,
  output logic signed [WIDTH-1:0] fixedPoint_angle
);

  // Datapath width: two extra integer bits absorb the CORDIC gain (~1.65*sqrt(2))
  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(ITERS + 1);
  // Working precision of the elaboration-time arctangent series
  localparam int P  = 60;

  // atan(1/n) scaled by 2^P, from the alternating Taylor series
  function automatic longint atan_inv(input longint n);
    longint term;
    longint sum;
    longint n2;
    term = (64'sd1 <<< P) / n;
    sum  = 64'sd0;
    n2   = n * n;
    for (int k = 0; k < 40; k++) begin
      if (k[0] == 1'b0) begin
        sum = sum + term / longint'(2 * k + 1);
      end else begin
        sum = sum - term / longint'(2 * k + 1);
      end
      term = term / n2;
    end
    return sum;
  endfunction

  // Packed table of round(atan(2^-i) * 2^FRACS).
  // Entry 0 uses Machin's formula (pi/4), because the series at x=1 converges too slowly.
  function automatic logic [ITERS*WIDTH-1:0] build_atan_tab();
    logic [ITERS*WIDTH-1:0] tab;
    longint                 v;
    tab = {(ITERS*WIDTH){1'b0}};
    for (int i = 0; i < ITERS; i++) begin
      if (i == 0) begin
        v = 64'sd4 * atan_inv(64'sd5) - atan_inv(64'sd239);
      end else begin
        v = atan_inv(64'sd1 <<< i);
      end
      v = (v + (64'sd1 <<< (P - FRACS - 1))) >>> (P - FRACS);
      tab[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
    end
    return tab;
  endfunction

  localparam logic [ITERS*WIDTH-1:0] ATAN_TAB = build_atan_tab();

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  logic signed [XW-1:0]    x_r;
  logic signed [XW-1:0]    y_r;
  logic signed [WIDTH-1:0] z_r;
  logic [CW-1:0]           cnt_r;
  logic                    zero_r;

  logic signed [XW-1:0]    x_shift_s;
  logic signed [XW-1:0]    y_shift_s;
  logic signed [WIDTH-1:0] atan_s;

  // Per-iteration shifted operands and arctangent constant for the current step
  always_comb begin
    x_shift_s = x_r >>> cnt_r;
    y_shift_s = y_r >>> cnt_r;
    if (cnt_r < CW'(ITERS)) begin
      atan_s = ATAN_TAB[int'(cnt_r) * WIDTH +: WIDTH];
    end else begin
      atan_s = {WIDTH{1'b0}};
    end
  end

  // Control FSM and datapath: sample, iterate, publish; everything freezes when clk_en is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      x_r              <= {XW{1'b0}};
      y_r              <= {XW{1'b0}};
      z_r              <= {WIDTH{1'b0}};
      cnt_r            <= {CW{1'b0}};
      zero_r           <= 1'b0;
      done             <= 1'b0;
      fixedPoint_angle <= {WIDTH{1'b0}};
    end else if (clk_en) begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            x_r     <= {3'b000, fixedPoint_x};
            y_r     <= {3'b000, fixedPoint_y};
            z_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            zero_r  <= (fixedPoint_x == {(WIDTH-1){1'b0}}) &&
                       (fixedPoint_y == {(WIDTH-1){1'b0}});
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // Rotate clockwise while y is non-negative, otherwise counter-clockwise
          if (!y_r[XW-1]) begin
            x_r <= x_r + y_shift_s;
            y_r <= y_r - x_shift_s;
            z_r <= z_r + atan_s;
          end else begin
            x_r <= x_r - y_shift_s;
            y_r <= y_r + x_shift_s;
            z_r <= z_r - atan_s;
          end
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(ITERS - 1)) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          // The origin has no defined angle; report 0 instead of the accumulated sum
          fixedPoint_angle <= zero_r ? {WIDTH{1'b0}} : z_r;
          done             <= 1'b1;
          state_r          <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Testbench for cordic_vectoring.
// Stimulus is directed plus randomised. Angles are checked against a
// real-valued atan2 reference, and latency is checked against edge counts.
module tb_cordic_vectoring;

  localparam int FRACS = 22;
  localparam int INTS  = 1;
  localparam int WIDTH = INTS + FRACS + 1;
  localparam int ITERS = FRACS;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    clk_en;
  logic                    start;
  logic                    done;
  logic [WIDTH-2:0]        fx;
  logic [WIDTH-2:0]        fy;
  logic signed [WIDTH-1:0] angle;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_vectoring #(
    .FRACS(FRACS), .INTS(INTS), .WIDTH(WIDTH), .ITERS(ITERS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (clk_en),
    .start           (start),
    .done            (done),
    .fixedPoint_x    (fx),
    .fixedPoint_y    (fy),
    .fixedPoint_angle(angle)
  );

  always #5 clk = ~clk;

  // Reference: exact atan2 in LSB units of the output angle
  function automatic real model_angle(input logic [WIDTH-2:0] x, input logic [WIDTH-2:0] y);
    if (x == 0 && y == 0) return 0.0;
    return $atan2(real'(y), real'(x)) * real'(64'd1 << FRACS);
  endfunction

  function automatic real absr(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge (edge T)
  task automatic launch(input logic [WIDTH-2:0] x, input logic [WIDTH-2:0] y);
    fx    = x;
    fy    = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is observed; -1 if the bound expires
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b1;
    fx     = 23'd4194304;
    fy     = 23'd4194304;
    tick();
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    n_checks++;
    if (angle !== 24'sd0) begin
      n_fail++;
      $display("FAIL reset_angle: got %0d expected 0", angle);
    end
    reset  = 1'b0;
    start  = 1'b0;
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [WIDTH-2:0] xs [4];
    logic [WIDTH-2:0] ys [4];
    int               ex [4];
    int               lat;
    xs = '{23'd4194304, 23'd4194304, 23'd0,       23'd0};
    ys = '{23'd0,       23'd4194304, 23'd2097152, 23'd0};
    ex = '{0, 3294199, 6588397, 0};
    for (int i = 0; i < 4; i++) begin
      launch(xs[i], ys[i]);
      wait_done(40, lat);
      n_checks++;
      if (lat !== ITERS + 1) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, ITERS + 1);
      end
      n_checks++;
      if (i == 3) begin
        if (angle !== 24'sd0) begin
          n_fail++;
          $display("FAIL basic_zero_angle: got %0d expected 0", angle);
        end
      end else if (!(absr(real'(angle) - real'(ex[i])) <= 8.0)) begin
        n_fail++;
        $display("FAIL basic_angle[%0d]: got %0d expected %0d +/-8", i, angle, ex[i]);
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_single_pulse[%0d]: got %b expected 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-2:0] x;
    logic [WIDTH-2:0] y;
    int               lat;
    real              m;
    for (int i = 0; i < 24; i++) begin
      x = 23'($urandom_range(0, 8388607));
      y = 23'($urandom_range(0, 8388607));
      if (x < 23'd4194304 && y < 23'd4194304) x = x | 23'd4194304;
      m = model_angle(x, y);
      launch(x, y);
      wait_done(40, lat);
      n_checks++;
      if (lat !== ITERS + 1) begin
        n_fail++;
        $display("FAIL random_latency x=%0d y=%0d: got %0d expected %0d", x, y, lat, ITERS + 1);
      end
      n_checks++;
      if (!(absr(real'(angle) - m) <= 8.0)) begin
        n_fail++;
        $display("FAIL random_angle x=%0d y=%0d: got %0d expected %0.1f +/-8", x, y, angle, m);
      end
    end
  endtask

  task automatic test_clk_en_run();
    logic signed [WIDTH-1:0] ang0;
    int                      lat;
    launch(23'd3000000, 23'd5000000);
    wait_done(40, lat);
    ang0 = angle;
    n_checks++;
    if (!(absr(real'(ang0) - model_angle(23'd3000000, 23'd5000000)) <= 8.0)) begin
      n_fail++;
      $display("FAIL clken_ref_angle: got %0d expected %0.1f +/-8", ang0,
               model_angle(23'd3000000, 23'd5000000));
    end
    tick();
    launch(23'd3000000, 23'd5000000);
    repeat (4) tick();
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || angle !== ang0) begin
        n_fail++;
        $display("FAIL clken_freeze: got done=%b angle=%0d expected done=0 angle=%0d", done, angle, ang0);
      end
    end
    clk_en = 1'b1;
    wait_done(40, lat);
    n_checks++;
    if (lat < 0 || lat + 9 !== ITERS + 6) begin
      n_fail++;
      $display("FAIL clken_latency: got %0d expected %0d", (lat < 0) ? -1 : lat + 9, ITERS + 6);
    end
    n_checks++;
    if (angle !== ang0) begin
      n_fail++;
      $display("FAIL clken_angle: got %0d expected %0d", angle, ang0);
    end
    tick();
  endtask

  task automatic test_clk_en_done();
    launch(23'd6000000, 23'd1234567);
    repeat (ITERS) tick();
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL clken_done_held: got %b expected 0", done);
      end
    end
    clk_en = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL clken_done_pulse: got %b expected 1", done);
    end
    n_checks++;
    if (!(absr(real'(angle) - model_angle(23'd6000000, 23'd1234567)) <= 8.0)) begin
      n_fail++;
      $display("FAIL clken_done_angle: got %0d expected %0.1f +/-8", angle,
               model_angle(23'd6000000, 23'd1234567));
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL clken_done_once: got %b expected 0", done);
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int first;
    n_done = 0;
    first  = -1;
    launch(23'd4194304, 23'd1000000);
    repeat (4) tick();
    fx    = 23'd100000;
    fy    = 23'd7000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 6; k <= 45; k++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = k;
      end
    end
    n_checks++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d expected 1", n_done);
    end
    n_checks++;
    if (first !== ITERS + 1) begin
      n_fail++;
      $display("FAIL ignore_latency: got %0d expected %0d", first, ITERS + 1);
    end
    n_checks++;
    if (!(absr(real'(angle) - model_angle(23'd4194304, 23'd1000000)) <= 8.0)) begin
      n_fail++;
      $display("FAIL ignore_angle: got %0d expected %0.1f +/-8", angle,
               model_angle(23'd4194304, 23'd1000000));
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    int lat;
    n_done = 0;
    launch(23'd2500000, 23'd3500000);
    repeat (9) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    reset = 1'b1;
    tick();
    if (done === 1'b1) n_done++;
    reset = 1'b0;
    n_checks++;
    if (angle !== 24'sd0) begin
      n_fail++;
      $display("FAIL rstmid_angle: got %0d expected 0", angle);
    end
    tick();
    if (done === 1'b1) n_done++;
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got %0d pulses expected 0", n_done);
    end
    launch(23'd5000000, 23'd800000);
    wait_done(40, lat);
    n_checks++;
    if (lat !== ITERS + 1) begin
      n_fail++;
      $display("FAIL rstmid_latency: got %0d expected %0d", lat, ITERS + 1);
    end
    n_checks++;
    if (!(absr(real'(angle) - model_angle(23'd5000000, 23'd800000)) <= 8.0)) begin
      n_fail++;
      $display("FAIL rstmid_angle_after: got %0d expected %0.1f +/-8", angle,
               model_angle(23'd5000000, 23'd800000));
    end
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    fx     = 23'd0;
    fy     = 23'd0;
    test_reset();
    test_basic();
    test_random();
    test_clk_en_run();
    test_clk_en_done();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
